ov5640_dvp_capture: RTL and testbench

//  Camera-side writer for the shared frame BRAM: samples OV5640 DVP (VSYNC/HREF/8-bit data) in the
//  cam_pclk domain, pairs bytes into RGB565 pixels, crops to cap_width x cap_height, and writes

---
 rtl/ov5640_dvp_capture_pkg.sv | 22 ++
 rtl/ov5640_dvp_capture_if.sv | 12 +
 rtl/ov5640_dvp_capture_packer.sv | 64 ++++++
 rtl/ov5640_dvp_capture.sv | 121 ++++++++++++
 tb/tb_ov5640_dvp_capture.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ov5640_dvp_capture_pkg.sv
// Types shared by the camera-side capture writer and the VGA read side of the frame BRAM.
package ov5640_dvp_capture_pkg;

    localparam int unsigned BRAM_AW = 17;
    // Sensor-side pixel/line counters; wide enough for any OV5640 line, saturating.
    localparam int unsigned CNT_W   = 12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } cap_state_t;

    typedef logic [15:0]        rgb565_t;
    typedef logic [BRAM_AW-1:0] bram_addr_t;

    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ov5640_dvp_capture_if.sv
// Frame BRAM write port (port A) driven by the camera capture block.
interface ov5640_dvp_capture_if;
    import ov5640_dvp_capture_pkg::*;

    bram_addr_t cam_bram_waddr;
    rgb565_t    cam_bram_wdata;
    logic       cam_bram_wen;

    modport master (output cam_bram_waddr, output cam_bram_wdata, output cam_bram_wen);
    modport slave  (input  cam_bram_waddr, input  cam_bram_wdata, input  cam_bram_wen);

endinterface

// File: rtl/ov5640_dvp_capture_packer.sv
// DVP input register stage: sync edge strobes and pairing of bytes into RGB565 pixels.
module ov5640_dvp_capture_packer
    import ov5640_dvp_capture_pkg::*;
#(
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       pix_valid,
    output rgb565_t    pix_data,
    output logic       line_end,
    output logic       line_odd,
    output logic       frame_start,
    output logic       frame_end
);

    logic       vsync_q, vsync_prev;
    logic       href_q, href_prev;
    logic [7:0] data_q, hi_byte;
    logic       phase;
    logic       vs_blank, vs_blank_prev;

    // Sync history resets to the active level so a sensor already mid-frame
    // at reset release can never produce a false frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q    <= ~VSYNC_POL;
            vsync_prev <= ~VSYNC_POL;
            href_q     <= 1'b0;
            href_prev  <= 1'b0;
            data_q     <= '0;
            hi_byte    <= '0;
            phase      <= 1'b0;
        end else begin
            vsync_q    <= cam_vsync;
            vsync_prev <= vsync_q;
            href_q     <= cam_href;
            href_prev  <= href_q;
            data_q     <= cam_data;
            if (clear || line_end) begin
                phase <= 1'b0;
            end else if (href_q) begin
                phase <= ~phase;
                if (!phase) hi_byte <= data_q;
            end
        end
    end

    always_comb begin
        vs_blank      = (vsync_q == VSYNC_POL);
        vs_blank_prev = (vsync_prev == VSYNC_POL);
        frame_start   = vs_blank_prev & ~vs_blank;
        frame_end     = ~vs_blank_prev & vs_blank;
        line_end      = href_prev & ~href_q;
        line_odd      = line_end & phase;
        pix_valid     = href_q & phase & ~clear;
        pix_data      = pack_rgb565(hi_byte, data_q);
    end

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP single-frame capture: crops RGB565 pixels and writes them row-major into BRAM port A.
module ov5640_dvp_capture
    import ov5640_dvp_capture_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH = 76800,
    parameter logic        VSYNC_POL  = 1'b1
) (
    input  logic                      cam_pclk,
    input  logic                      sys_rst,
    input  logic                      cam_vsync,
    input  logic                      cam_href,
    input  logic [7:0]                cam_data,
    input  logic                      axil_capture_start,
    input  logic [8:0]                axil_cap_width,
    input  logic [8:0]                axil_cap_height,
    ov5640_dvp_capture_if.master      bram,
    output logic                      axil_capture_busy,
    output logic                      axil_capture_done,
    output logic                      axil_capture_err
);

    cap_state_t       state, state_next;
    logic [8:0]       cap_w, cap_h;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    bram_addr_t       addr_cnt;

    logic    pix_valid, line_end, line_odd, frame_start, frame_end;
    rgb565_t pix_data;
    logic    start_ok, in_crop, addr_ok, do_write;

    ov5640_dvp_capture_packer #(.VSYNC_POL(VSYNC_POL)) u_packer (
        .clk         (cam_pclk),
        .rst         (sys_rst),
        .clear       (state != CAPTURE),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .line_end    (line_end),
        .line_odd    (line_odd),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always_ff @(posedge cam_pclk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next        = state;
        axil_capture_busy = 1'b0;
        axil_capture_done = 1'b0;
        case (state)
            IDLE:    if (axil_capture_start) state_next = WAIT_VS;
            WAIT_VS: begin
                axil_capture_busy = 1'b1;
                if (frame_start) state_next = CAPTURE;
            end
            CAPTURE: begin
                axil_capture_busy = 1'b1;
                if (frame_end) state_next = DONE;
            end
            DONE: begin
                axil_capture_done = 1'b1;
                if (axil_capture_start) state_next = WAIT_VS;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only cropped pixels are written, consecutively, so a running counter
    // yields h + v*width; the depth gate makes it saturate rather than wrap.
    always_comb begin
        start_ok = axil_capture_start && (state == IDLE || state == DONE);
        in_crop  = (h_cnt < CNT_W'(cap_w)) && (v_cnt < CNT_W'(cap_h));
        addr_ok  = 32'(addr_cnt) < BRAM_DEPTH;
        do_write = (state == CAPTURE) && pix_valid && in_crop && addr_ok;
    end

    always_ff @(posedge cam_pclk) begin
        if (sys_rst) begin
            cap_w               <= '0;
            cap_h               <= '0;
            h_cnt               <= '0;
            v_cnt               <= '0;
            addr_cnt            <= '0;
            axil_capture_err    <= 1'b0;
            bram.cam_bram_wen   <= 1'b0;
            bram.cam_bram_waddr <= '0;
            bram.cam_bram_wdata <= '0;
        end else begin
            bram.cam_bram_wen <= do_write;
            if (do_write) begin
                bram.cam_bram_waddr <= addr_cnt;
                bram.cam_bram_wdata <= pix_data;
                addr_cnt            <= addr_cnt + 1'b1;
            end
            if (start_ok) begin
                cap_w            <= axil_cap_width;
                cap_h            <= axil_cap_height;
                axil_capture_err <= 1'b0;
            end
            if (state == WAIT_VS && frame_start) begin
                h_cnt    <= '0;
                v_cnt    <= '0;
                addr_cnt <= '0;
            end
            if (state == CAPTURE) begin
                if (pix_valid && h_cnt != '1) h_cnt <= h_cnt + 1'b1;
                if (line_end) begin
                    h_cnt <= '0;
                    if (h_cnt != '0 && v_cnt != '1) v_cnt <= v_cnt + 1'b1;
                    if (line_odd) axil_capture_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Scoreboard bench for ov5640_dvp_capture: a sensor model drives DVP frames, expected writes are queued.
module tb_ov5640_dvp_capture;

    localparam int unsigned DEPTH = 300;

    logic       clk = 1'b0;
    logic       sys_rst, cam_vsync, cam_href, axil_capture_start;
    logic [7:0] cam_data;
    logic [8:0] cap_w, cap_h;
    logic       busy, done, err;

    always #5 clk = ~clk;

    ov5640_dvp_capture_if bram_if ();

    ov5640_dvp_capture #(.BRAM_DEPTH(DEPTH), .VSYNC_POL(1'b1)) dut (
        .cam_pclk           (clk),
        .sys_rst            (sys_rst),
        .cam_vsync          (cam_vsync),
        .cam_href           (cam_href),
        .cam_data           (cam_data),
        .axil_capture_start (axil_capture_start),
        .axil_cap_width     (cap_w),
        .axil_cap_height    (cap_h),
        .bram               (bram_if),
        .axil_capture_busy  (busy),
        .axil_capture_done  (done),
        .axil_capture_err   (err)
    );

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;
    logic [16:0] last_addr;
    logic [15:0] mem [0:511];

    // Reference model of the capture control state
    bit arming = 0, cap_active = 0, done_m = 0, err_m = 0;
    int lat_w = 0, lat_h = 0;
    bit rst_chk = 0, start_req = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bram_if.cam_bram_wen === 1'b1) begin
            wr_count++;
            last_addr = bram_if.cam_bram_waddr;
            mem[bram_if.cam_bram_waddr[8:0]] = bram_if.cam_bram_wdata;
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", 32'(bram_if.cam_bram_waddr), 32'(mon_e.addr));
                check("wdata", 32'(bram_if.cam_bram_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic tick(input logic hr, input logic [7:0] d);
        @(negedge clk);
        if (rst_chk) begin
            check("rst_wen",   32'(bram_if.cam_bram_wen),   32'd0);
            check("rst_waddr", 32'(bram_if.cam_bram_waddr), 32'd0);
            check("rst_wdata", 32'(bram_if.cam_bram_wdata), 32'd0);
            check("rst_busy",  32'(busy), 32'd0);
            check("rst_done",  32'(done), 32'd0);
            check("rst_err",   32'(err),  32'd0);
            sys_rst = 1'b0;
            rst_chk = 0;
        end
        axil_capture_start = start_req;
        start_req = 0;
        cam_href  = hr;
        cam_data  = d;
    endtask

    task automatic do_start(input int w, input int h);
        cap_w     = 9'(w);
        cap_h     = 9'(h);
        start_req = 1;
        if (!(arming || cap_active)) begin
            arming = 1;
            done_m = 0;
            err_m  = 0;
            lat_w  = w;
            lat_h  = h;
        end
    endtask

    // pw pixels per line, nl lines; odd_line gets one extra byte; optional start
    // pulse at start_line and sys_rst at frame pixel rst_pix (-1 disables).
    task automatic send_frame(input int pw, input int nl, input int odd_line,
                              input int start_line, input int sw, input int sh,
                              input int rst_pix);
        int b = 0, h = 0, v = 0, gp = 0, nb, ea = 0;
        cam_vsync = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        cam_vsync  = 1'b0;
        cap_active = arming;
        arming     = 0;
        repeat (3) tick(1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            if (l == start_line) do_start(sw, sh);
            nb = (l == odd_line) ? 2 * pw + 1 : 2 * pw;
            if (cap_active && (nb % 2 == 1)) err_m = 1;
            for (int i = 0; i < nb; i++) begin
                tick(1'b1, 8'(b));
                b++;
                if (i % 2 == 1) begin
                    if (gp == rst_pix) begin
                        sys_rst    = 1'b1;
                        rst_chk    = 1;
                        cap_active = 0;
                        arming     = 0;
                        done_m     = 0;
                        err_m      = 0;
                    end else if (cap_active && h < lat_w && v < lat_h && ea < DEPTH) begin
                        exp_q.push_back('{addr: 17'(ea), data: {8'(b - 2), 8'(b - 1)}});
                        ea++;
                    end
                    h++;
                    gp++;
                end
            end
            repeat (4) tick(1'b0, 8'h00);
            if (h > 0) v++;
            h = 0;
        end
        tick(1'b0, 8'h00);
        cam_vsync = 1'b1;
        repeat (4) tick(1'b0, 8'h00);
        if (cap_active) done_m = 1;
        cap_active = 0;
        check("frame_done",    32'(done), 32'(done_m));
        check("frame_busy",    32'(busy), 32'(arming));
        check("frame_err",     32'(err),  32'(err_m));
        check("frame_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_data = 8'h00;
        axil_capture_start = 1'b0;
        cap_w = '0;
        cap_h = '0;
        repeat (3) @(negedge clk);
        check("reset_wen",   32'(bram_if.cam_bram_wen),   32'd0);
        check("reset_waddr", 32'(bram_if.cam_bram_waddr), 32'd0);
        check("reset_wdata", 32'(bram_if.cam_bram_wdata), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        check("reset_err",   32'(err),  32'd0);
        sys_rst = 1'b0;

        // Basic crop 4x2 out of a 6x3 sensor frame
        do_start(4, 2);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("armed_busy", 32'(busy), 32'd1);
        wr_count = 0;
        send_frame(6, 3, -1, -1, 0, 0, -1);
        check("t1_count", 32'(wr_count), 32'd8);
        check("t1_last",  32'(last_addr), 32'd7);
        check("t1_pix0",  32'(mem[0]), 32'h0001);
        check("t1_pix4",  32'(mem[4]), 32'h0C0D);

        // Start mid-frame: that frame skipped; next one captured, busy start ignored
        wr_count = 0;
        send_frame(5, 4, -1, 2, 5, 4, -1);
        check("t2_skip_count", 32'(wr_count), 32'd0);
        send_frame(5, 4, -1, 1, 9, 9, -1);
        check("t2_count", 32'(wr_count), 32'd20);

        // Odd byte count on a line
        do_start(3, 3);
        wr_count = 0;
        send_frame(3, 3, 1, -1, 0, 0, -1);
        check("t3_count", 32'(wr_count), 32'd9);
        check("t3_err",   32'(err), 32'd1);
        do_start(20, 15);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("t3_err_clr",  32'(err),  32'd0);
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_busy",     32'(busy), 32'd1);

        // Crop exactly fills the BRAM, then an oversized crop saturates
        wr_count = 0;
        send_frame(40, 30, -1, -1, 0, 0, -1);
        check("t4_full_count", 32'(wr_count), 32'(DEPTH));
        check("t4_full_last",  32'(last_addr), 32'(DEPTH - 1));
        do_start(511, 511);
        wr_count = 0;
        send_frame(40, 30, -1, -1, 0, 0, -1);
        check("t4_sat_count", 32'(wr_count), 32'(DEPTH));
        check("t4_sat_last",  32'(last_addr), 32'(DEPTH - 1));

        // Reset during capture at pixel 10, then a fresh capture
        do_start(6, 3);
        wr_count = 0;
        send_frame(6, 3, -1, -1, 0, 0, 10);
        check("t5_count", 32'(wr_count), 32'd10);
        do_start(6, 3);
        wr_count = 0;
        send_frame(6, 3, -1, -1, 0, 0, -1);
        check("t5_fresh_count", 32'(wr_count), 32'd18);

        // Zero width: no writes, still completes; start in DONE re-arms
        do_start(0, 2);
        wr_count = 0;
        send_frame(4, 2, -1, -1, 0, 0, -1);
        check("t6_count", 32'(wr_count), 32'd0);
        check("t6_done",  32'(done), 32'd1);
        do_start(4, 2);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("t6_rearm_busy", 32'(busy), 32'd1);
        check("t6_rearm_done", 32'(done), 32'd0);
        send_frame(4, 2, -1, -1, 0, 0, -1);
        check("t6_count2", 32'(wr_count), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
